// File: rtl/s641_misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : s641_misr_compactor
// Purpose  : Response compactor for the s641 benchmark. Valid output vectors
//            are first discarded for a flush window of SKIP beats, then the
//            next `cycles` beats are folded into a MISR signature. The final
//            signature is compared against a host-supplied golden value.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            i_start            - run request (accepted in IDLE or DONE)
//            i_cycles, i_golden - run length / expected signature, latched
//                                 on an accepted start
//            i_resp_valid/data  - s641 primary-output vector stream
//            o_busy, o_done     - handshake (FLUSH|RUN, DONE)
//            o_pass             - signature matched golden (valid with done)
//            o_signature        - current MISR contents
//            o_count            - samples compacted so far
// Revision : 1.0 - initial release
// ============================================================================
module s641_misr_compactor #(
  parameter int               IN_W  = 24,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int               SKIP  = 19,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cycles,
  input  logic [SIG_W-1:0] i_golden,
  input  logic             i_resp_valid,
  input  logic [IN_W-1:0]  i_resp_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_signature,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Skip counter is at least one bit wide even when the flush window is empty.
  localparam int               SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [SIG_W-1:0]  r_sig;
  logic [CNT_W-1:0]  r_count;
  logic [SKIP_W-1:0] r_skip;
  logic [CNT_W-1:0]  r_cycles;
  logic [SIG_W-1:0]  r_golden;
  logic              r_pass;

  logic              w_accept;
  logic              w_flush_end;
  logic              w_run_beat;
  logic              w_last;
  logic [SIG_W-1:0]  w_sig_next;

  assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_flush_end = (r_state == S_FLUSH) && i_resp_valid && (r_skip == SKIP_LAST);
  assign w_run_beat  = (r_state == S_RUN) && i_resp_valid;
  assign w_last      = (r_count == (r_cycles - CNT_W'(1)));

  // Galois-style shift with polynomial feedback, then inject the zero-extended
  // response vector.
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(i_resp_data);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (i_cycles == '0) begin
            w_state_next = S_DONE;
          end else if (SKIP > 0) begin
            w_state_next = S_FLUSH;
          end else begin
            w_state_next = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        if (w_flush_end) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_beat && w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_FLUSH, S_RUN: o_busy = 1'b1;
      S_DONE:         o_done = 1'b1;
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  // Datapath: run parameters, signature, counters and verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig    <= SEED;
      r_count  <= '0;
      r_skip   <= '0;
      r_cycles <= '0;
      r_golden <= '0;
      r_pass   <= 1'b0;
    end else if (w_accept) begin
      r_sig    <= SEED;
      r_count  <= '0;
      r_skip   <= '0;
      r_cycles <= i_cycles;
      r_golden <= i_golden;
      // A zero-length run goes straight to DONE with the seed as its result.
      r_pass   <= (i_cycles == '0) ? (SEED == i_golden) : 1'b0;
    end else if ((r_state == S_FLUSH) && i_resp_valid) begin
      r_skip <= r_skip + SKIP_W'(1);
    end else if (w_run_beat) begin
      r_sig   <= w_sig_next;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_pass <= (w_sig_next == r_golden);
      end
    end
  end

  assign o_pass      = r_pass;
  assign o_signature = r_sig;
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_s641_misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_s641_misr_compactor
// Purpose  : Directed bench for s641_misr_compactor. Instance u_a uses the
//            default parameters; u_b uses SEED=0, SKIP=0. Both share stimulus
//            and each scenario checks the instance it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s641_misr_compactor;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_cycles;
  logic [31:0] i_golden;
  logic        i_resp_valid;
  logic [23:0] i_resp_data;

  logic        a_busy, a_done, a_pass;
  logic [31:0] a_sig;
  logic [15:0] a_count;
  logic        b_busy, b_done, b_pass;
  logic [31:0] b_sig;
  logic [15:0] b_count;

  int n_cmp;
  int n_bad;

  s641_misr_compactor u_a (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_cycles     (i_cycles),
    .i_golden     (i_golden),
    .i_resp_valid (i_resp_valid),
    .i_resp_data  (i_resp_data),
    .o_busy       (a_busy),
    .o_done       (a_done),
    .o_pass       (a_pass),
    .o_signature  (a_sig),
    .o_count      (a_count)
  );

  s641_misr_compactor #(
    .SEED (32'h00000000),
    .SKIP (0)
  ) u_b (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_cycles     (i_cycles),
    .i_golden     (i_golden),
    .i_resp_valid (i_resp_valid),
    .i_resp_data  (i_resp_data),
    .o_busy       (b_busy),
    .o_done       (b_done),
    .o_pass       (b_pass),
    .o_signature  (b_sig),
    .o_count      (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic beat(input logic [23:0] d);
    i_resp_valid = 1'b1;
    i_resp_data  = d;
    tick();
    i_resp_valid = 1'b0;
    i_resp_data  = '0;
  endtask

  task automatic go(input logic [15:0] cyc, input logic [31:0] gold);
    i_start  = 1'b1;
    i_cycles = cyc;
    i_golden = gold;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_cycles     = '0;
    i_golden     = '0;
    i_resp_valid = 1'b0;
    i_resp_data  = '0;

    // ---- Reset state ----
    do_reset();
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_done",  {31'd0, a_done}, 32'd0);
    chk("rst_pass",  {31'd0, a_pass}, 32'd0);
    chk("rst_sig",   a_sig,           32'hFFFFFFFF);
    chk("rst_count", {16'd0, a_count}, 32'd0);

    // ---- Defaults: 19 flush beats, then one zero sample ----
    go(16'd1, 32'hFB3EE249);
    chk("d_busy_flush", {31'd0, a_busy}, 32'd1);
    for (int i = 0; i < 19; i++) beat(24'hA5C3F0 ^ 24'(i * 24'h010203));
    chk("d_sig_after_flush", a_sig, 32'hFFFFFFFF);
    chk("d_busy_run", {31'd0, a_busy}, 32'd1);
    beat(24'h000000);
    chk("d_busy", {31'd0, a_busy}, 32'd0);
    chk("d_done", {31'd0, a_done}, 32'd1);
    chk("d_sig",  a_sig,           32'hFB3EE249);
    chk("d_pass", {31'd0, a_pass}, 32'd1);
    chk("d_count", {16'd0, a_count}, 32'd1);
    beat(24'h123456);
    idle(2);
    chk("d_hold_sig",  a_sig,           32'hFB3EE249);
    chk("d_hold_done", {31'd0, a_done}, 32'd1);

    // ---- SEED=0, SKIP=0: two samples of 1, golden mismatch ----
    do_reset();
    chk("b_rst_sig", b_sig, 32'h00000000);
    go(16'd2, 32'h00000002);
    chk("b_busy", {31'd0, b_busy}, 32'd1);
    beat(24'h000001);
    beat(24'h000001);
    chk("b_done",  {31'd0, b_done}, 32'd1);
    chk("b_sig",   b_sig,           32'h00000003);
    chk("b_pass",  {31'd0, b_pass}, 32'd0);
    chk("b_count", {16'd0, b_count}, 32'd2);

    // ---- Bubbles: gaps of 0/3/5 cycles between valid beats ----
    do_reset();
    go(16'd3, 32'h00000007);
    beat(24'h000001);
    idle(3);
    beat(24'h000001);
    chk("bub_count2", {16'd0, b_count}, 32'd2);
    idle(5);
    chk("bub_not_done", {31'd0, b_done}, 32'd0);
    chk("bub_busy", {31'd0, b_busy}, 32'd1);
    beat(24'h000001);
    chk("bub_done", {31'd0, b_done}, 32'd1);
    chk("bub_sig",  b_sig,           32'h00000007);
    chk("bub_pass", {31'd0, b_pass}, 32'd1);

    // ---- cycles=0: straight to DONE, pass against SEED ----
    do_reset();
    i_resp_valid = 1'b1;
    i_resp_data  = 24'hFFFFFF;
    go(16'd0, 32'hFFFFFFFF);
    chk("z_done",  {31'd0, a_done}, 32'd1);
    chk("z_busy",  {31'd0, a_busy}, 32'd0);
    chk("z_sig",   a_sig,           32'hFFFFFFFF);
    chk("z_pass",  {31'd0, a_pass}, 32'd1);
    beat(24'h00ABCD);
    chk("z_sig_hold", a_sig, 32'hFFFFFFFF);
    go(16'd0, 32'h12345678);
    chk("z_pass_bad", {31'd0, a_pass}, 32'd0);
    chk("z_done2",    {31'd0, a_done}, 32'd1);

    // ---- start while busy is ignored; restart from DONE ----
    do_reset();
    go(16'd4, 32'h0000000F);
    beat(24'h000001);
    i_start  = 1'b1;
    i_cycles = 16'd1;
    i_golden = 32'h00000000;
    beat(24'h000001);
    i_start = 1'b0;
    chk("sb_count2", {16'd0, b_count}, 32'd2);
    chk("sb_busy2",  {31'd0, b_busy},  32'd1);
    beat(24'h000001);
    chk("sb_not_done", {31'd0, b_done}, 32'd0);
    beat(24'h000001);
    chk("sb_done",  {31'd0, b_done}, 32'd1);
    chk("sb_sig",   b_sig,           32'h0000000F);
    chk("sb_pass",  {31'd0, b_pass}, 32'd1);
    chk("sb_count", {16'd0, b_count}, 32'd4);
    go(16'd1, 32'h00000001);
    chk("rs_done", {31'd0, b_done}, 32'd0);
    chk("rs_busy", {31'd0, b_busy}, 32'd1);
    chk("rs_sig",  b_sig,           32'h00000000);
    chk("rs_count", {16'd0, b_count}, 32'd0);
    beat(24'h000001);
    chk("rs_done2", {31'd0, b_done}, 32'd1);
    chk("rs_sig2",  b_sig,           32'h00000001);
    chk("rs_pass2", {31'd0, b_pass}, 32'd1);

    // ---- Asynchronous reset mid-RUN ----
    do_reset();
    go(16'd5, 32'h00000000);
    for (int i = 0; i < 19; i++) beat(24'h000000);
    beat(24'h000000);
    beat(24'h000000);
    chk("ar_pre_count", {16'd0, a_count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy",  {31'd0, a_busy}, 32'd0);
    chk("ar_done",  {31'd0, a_done}, 32'd0);
    chk("ar_pass",  {31'd0, a_pass}, 32'd0);
    chk("ar_sig",   a_sig,           32'hFFFFFFFF);
    chk("ar_count", {16'd0, a_count}, 32'd0);
    #1 rst = 1'b0;
    tick();
    go(16'd1, 32'hFB3EE249);
    for (int i = 0; i < 19; i++) beat(24'h5A5A5A);
    beat(24'h000000);
    chk("ar_rerun_done", {31'd0, a_done}, 32'd1);
    chk("ar_rerun_sig",  a_sig,           32'hFB3EE249);
    chk("ar_rerun_pass", {31'd0, a_pass}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
